debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised N-channel debouncer for buttons, switches and other slow mechanical inputs. Each channel has its own synchroniser, a per-channel consecutive-sample counter for symmetric press and release filtering, and single-cycle edge strobes. All channels share one sample-tick divider. It sits between top-level pins and user logic, and replaces the single-channel debouncer for boards with several buttons.

## Interface

**Parameters**

- `CHANNELS`, default 4: number of independent inputs, 1..32.
- `CLK_HZ`, default 12000000: system clock frequency in Hz.
- `SAMPLE_HZ`, default 1000: sample-tick rate. `CLK_HZ/SAMPLE_HZ` must be ≥ 2 and an exact integer.
- `STABLE_COUNT`, default 8: consecutive disagreeing samples needed to change state, 1..255.
- `ACTIVE_LOW`, default 0: 1 inverts the raw inputs, so a pin at 0 reads as pressed.
- `HOLD_TICKS`, default 1000: samples of continuous press before the hold event, 1..65535. Used only with `DEBOUNCE_HOLD_EN`.

**Ports**

- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `btn_in` input, `CHANNELS` bits: raw asynchronous inputs.
- `btn_db` output, `CHANNELS` bits: debounced logical state, 1 = pressed.
- `btn_rise` output, `CHANNELS` bits: one-cycle strobe when `btn_db` goes 0→1.
- `btn_fall` output, `CHANNELS` bits: one-cycle strobe when `btn_db` goes 1→0.
- `btn_hold` output, `CHANNELS` bits: level, asserted while the press has lasted `HOLD_TICKS` samples.
- `btn_hold_pulse` output, `CHANNELS` bits: one-cycle strobe when `btn_hold` asserts.
- `sample_tick` output, 1 bit: the shared tick, exported so user logic can use it.

## Operation

**Synchroniser**
- Two flops per channel.
- Polarity inversion per `ACTIVE_LOW` is applied before the first flop.
- Synchroniser flops reset to logical 0, i.e. not pressed.

**Tick divider**
- Counter is `$clog2(CLK_HZ/SAMPLE_HZ)` bits wide and counts 0..`CLK_HZ/SAMPLE_HZ`−1.
- `sample_tick` is high for one cycle at terminal count, then the counter wraps to 0.

**Per-channel filter**
- State is `btn_db[i]` plus an 8-bit counter `cnt[i]`. All update only on `sample_tick`.
- If the synchronised sample equals `btn_db[i]`: `cnt[i]` ← 0.
- If the sample differs and `cnt[i]` = `STABLE_COUNT`−1: toggle `btn_db[i]` and set `cnt[i]` ← 0.
- If the sample differs otherwise: increment `cnt[i]`.
- Press and release are filtered symmetrically. A single agreeing sample restarts the count.
- `btn_rise[i]` / `btn_fall[i]` are registered in the same edge that toggles `btn_db[i]`, and clear on the next cycle.

**Hold detection** (see Configuration)
- 16-bit `hcnt[i]` counts ticks while `btn_db[i]`=1 and saturates at `HOLD_TICKS`.
- When it reaches `HOLD_TICKS`: `btn_hold[i]` ← 1 and `btn_hold_pulse[i]` strobes once.
- When `btn_db[i]` goes to 0: `hcnt[i]` and `btn_hold[i]` clear in the same edge as `btn_fall[i]`.

**Simultaneous events**
- Channels are fully independent.
- Any subset may strobe in the same cycle.

## Timing

- **Reset values:** all outputs 0; all counters 0. This holds on assertion regardless of clock, including mid-count. After release, the first tick occurs `CLK_HZ/SAMPLE_HZ` cycles later.
- **Synchroniser latency:** 2 clocks.
- **Filter latency:** a clean input edge makes `btn_db` change on the `STABLE_COUNT`-th tick whose sample differs.
  - Worst case from the pin: 2 + `STABLE_COUNT`·(`CLK_HZ/SAMPLE_HZ`) clocks.
  - Best case: 2 + (`STABLE_COUNT`−1)·(`CLK_HZ/SAMPLE_HZ`) + 1 clocks.
- **Edge strobes:** exactly 1 clock wide, coincident with the `btn_db` change, and always aligned with `sample_tick` asserted in that cycle.
- **`STABLE_COUNT` = 1:** `btn_db` follows the synchronised input on every tick, with no filtering.
- **Input toggling faster than the stable window:** `btn_db` never changes.

## Configuration

- **Macro:** `DEBOUNCE_HOLD_EN`.
- **Defined:** `hcnt` counters and hold logic are compiled in, with behaviour as above.
- **Undefined:**
  - No hold counters are synthesised.
  - `btn_hold` and `btn_hold_pulse` are still present as ports but are tied to constant 0.
  - `HOLD_TICKS` is ignored.
  - All other behaviour is identical.

## Test plan

Common setup: `CLK_HZ`=1000, `SAMPLE_HZ`=100 (tick every 10 clocks), `STABLE_COUNT`=4, `CHANNELS`=4.

- **Reset:** assert `rst_n`=0 mid-count with `btn_in`=4'hF → all outputs 0 immediately and no strobes. After release, `sample_tick` first pulses at clock 10.
- **Clean press:** `btn_in[0]` 0→1 and held → `btn_db[0]`=1 on the 4th tick after sync, with `btn_rise[0]` one cycle wide in that cycle. Release gives `btn_fall[0]` after another 4 ticks.
- **Bounce:** `btn_in[1]` toggles every 15 clocks for 200 clocks, then settles at 1 → no change during bouncing; `btn_db[1]`=1 exactly 4 ticks after settling.
- **Glitch during release:** pressed channel sees 3 zero samples, then 1 one, then steady 0 → release strobe only after 4 further consecutive zero samples.
- **Simultaneous channels, `ACTIVE_LOW`=1:** `btn_in` 4'hF→4'h5 → `btn_rise`=4'hA in a single cycle, with `btn_db`=4'hA.
- **Hold (`DEBOUNCE_HOLD_EN`, `HOLD_TICKS`=20):** hold ch2 for 30 ticks → `btn_hold_pulse[2]` fires once, 20 ticks after `btn_rise[2]`, and `btn_hold[2]` stays 1 until the fall. Without the macro, both hold outputs stay 0.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi -- N-channel debouncer for buttons, switches and other slow
// mechanical inputs, with one sample-tick divider shared by all channels.
//
// Each channel has a two-flop synchroniser (with optional polarity inversion
// ahead of it) and a consecutive-sample filter. The filter changes state only
// after STABLE_COUNT samples in a row that disagree with it, so presses and
// releases are filtered the same way. The channel also produces one-cycle
// rise/fall strobes.
//
// Optional feature macro: DEBOUNCE_HOLD_EN
//   defined   : per-channel hold counters drive btn_hold / btn_hold_pulse
//   undefined : no hold counters; btn_hold / btn_hold_pulse tied to 0
//
// Ports
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   btn_in         : raw asynchronous inputs, one bit per channel
//   btn_db         : debounced state, 1 = pressed
//   btn_rise       : one-cycle strobe when btn_db goes 0->1
//   btn_fall       : one-cycle strobe when btn_db goes 1->0
//   btn_hold       : level, press has lasted HOLD_TICKS samples
//   btn_hold_pulse : one-cycle strobe when btn_hold asserts
//   sample_tick    : shared sample tick, one cycle wide
module debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int CLK_HZ       = 12000000,
  parameter int SAMPLE_HZ    = 1000,
  parameter int STABLE_COUNT = 8,
  parameter int ACTIVE_LOW   = 0,
  parameter int HOLD_TICKS   = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_db,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_hold,
  output logic [CHANNELS-1:0] btn_hold_pulse,
  output logic                sample_tick
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] DIV_TC = TW'(DIV - 1);
  localparam logic [7:0] CNT_TC = 8'(STABLE_COUNT - 1);
  localparam logic [CHANNELS-1:0] POL_MASK = {CHANNELS{ACTIVE_LOW != 0}};

  // Elaboration-time parameter checks.
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_chk_channels
    $error("debounce_multi: CHANNELS out of range 1..32");
  end
  if (DIV < 2 || (DIV * SAMPLE_HZ) != CLK_HZ) begin : g_chk_div
    $error("debounce_multi: CLK_HZ/SAMPLE_HZ must be an integer >= 2");
  end
  if (STABLE_COUNT < 1 || STABLE_COUNT > 255) begin : g_chk_stable
    $error("debounce_multi: STABLE_COUNT out of range 1..255");
  end
  if (HOLD_TICKS < 1 || HOLD_TICKS > 65535) begin : g_chk_hold
    $error("debounce_multi: HOLD_TICKS out of range 1..65535");
  end

  logic [CHANNELS-1:0]      sync1_q, sync1_d;
  logic [CHANNELS-1:0]      sync2_q, sync2_d;
  logic [TW-1:0]            div_q, div_d;
  logic                     tick_en;
  logic                     sample_tick_q, sample_tick_d;
  logic [CHANNELS-1:0]      db_q, db_d;
  logic [CHANNELS-1:0]      rise_q, rise_d;
  logic [CHANNELS-1:0]      fall_q, fall_d;
  logic [CHANNELS-1:0][7:0] cnt_q, cnt_d;

  // Synchroniser; inversion sits in front of the first flop so both flops
  // carry the logical (1 = pressed) value and reset to "not pressed".
  always_comb begin
    sync1_d = btn_in ^ POL_MASK;
    sync2_d = sync1_q;
  end

  // The filter updates on the edge where the divider wraps; sample_tick is
  // registered from the same condition so it is high in exactly the cycle
  // where the registered strobes appear.
  always_comb begin
    tick_en       = (div_q == DIV_TC);
    div_d         = tick_en ? '0 : div_q + 1'b1;
    sample_tick_d = tick_en;
  end

  always_comb begin
    db_d   = db_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    if (tick_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_TC) begin
          db_d[i]   = ~db_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = ~db_q[i];
          fall_d[i] = db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      div_q         <= '0;
      sample_tick_q <= 1'b0;
      db_q          <= '0;
      cnt_q         <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      div_q         <= div_d;
      sample_tick_q <= sample_tick_d;
      db_q          <= db_d;
      cnt_q         <= cnt_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
    end
  end

  assign btn_db      = db_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign sample_tick = sample_tick_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [15:0] HOLD_TC_M1 = 16'(HOLD_TICKS - 1);

  logic [CHANNELS-1:0][15:0] hcnt_q, hcnt_d;
  logic [CHANNELS-1:0]       hold_q, hold_d;
  logic [CHANNELS-1:0]       hpulse_q, hpulse_d;

  // hcnt counts ticks on which the channel was already pressed, so the hold
  // pulse lands HOLD_TICKS ticks after the rise strobe. Release clears the
  // counter and the level on the same edge as the fall strobe.
  always_comb begin
    hcnt_d   = hcnt_q;
    hold_d   = hold_q;
    hpulse_d = '0;
    if (tick_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (fall_d[i]) begin
          hcnt_d[i] = '0;
          hold_d[i] = 1'b0;
        end else if (db_q[i] && !hold_q[i]) begin
          hcnt_d[i] = hcnt_q[i] + 16'd1;
          if (hcnt_q[i] == HOLD_TC_M1) begin
            hold_d[i]   = 1'b1;
            hpulse_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q   <= '0;
      hold_q   <= '0;
      hpulse_q <= '0;
    end else begin
      hcnt_q   <= hcnt_d;
      hold_q   <= hold_d;
      hpulse_q <= hpulse_d;
    end
  end

  assign btn_hold       = hold_q;
  assign btn_hold_pulse = hpulse_q;
`else
  assign btn_hold       = '0;
  assign btn_hold_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi. Two instances: dut0 with
// ACTIVE_LOW=0, dut1 with ACTIVE_LOW=1. Expected strobe events are queued
// with their predicted edge number when stimulus is driven and compared when
// the DUT raises a strobe.
module tb_debounce_multi;

  localparam int DIV = 10;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic HOLD_ON = 1'b1;
`else
  localparam logic HOLD_ON = 1'b0;
`endif

  typedef struct {
    int         edg;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hp;
    logic [3:0] db;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn0, btn1;
  logic [3:0] db0, rise0, fall0, hold0, hp0;
  logic [3:0] db1, rise1, fall1, hold1, hp1;
  logic       tick0, tick1;

  int  cyc;
  int  n_checks;
  int  n_errors;
  ev_t q0[$];
  ev_t q1[$];
  ev_t e0, e1;

  debounce_multi #(
    .CHANNELS(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_COUNT(4),
    .ACTIVE_LOW(0), .HOLD_TICKS(20)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn0), .btn_db(db0),
    .btn_rise(rise0), .btn_fall(fall0), .btn_hold(hold0),
    .btn_hold_pulse(hp0), .sample_tick(tick0)
  );

  debounce_multi #(
    .CHANNELS(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_COUNT(4),
    .ACTIVE_LOW(1), .HOLD_TICKS(20)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn1), .btn_db(db1),
    .btn_rise(rise1), .btn_fall(fall1), .btn_hold(hold1),
    .btn_hold_pulse(hp1), .sample_tick(tick1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: value N at a negedge means N rising edges since reset
  // release; the divider ticks on edges that are multiples of DIV.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Input driven at a negedge with edge count n: first filter tick that sees
  // it is the first multiple of DIV at or after n+3; the k-th such tick
  // changes btn_db.
  function automatic int exp_edge(input int n, input int k);
    int x;
    x = ((n + 3 + DIV - 1) / DIV) * DIV;
    return x + DIV * (k - 1);
  endfunction

  task automatic wait_until(input int t);
    for (int i = 0; i < 2000; i++) begin
      if (cyc >= t) break;
      @(negedge clk);
    end
  endtask

  task automatic push0(input int edg, input logic [3:0] r, input logic [3:0] f,
                       input logic [3:0] h, input logic [3:0] d);
    ev_t e;
    e.edg = edg; e.rise = r; e.fall = f; e.hp = h; e.db = d;
    q0.push_back(e);
  endtask

  task automatic push1(input int edg, input logic [3:0] r, input logic [3:0] f,
                       input logic [3:0] d);
    ev_t e;
    e.edg = edg; e.rise = r; e.fall = f; e.hp = 4'h0; e.db = d;
    q1.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (|{rise0, fall0, hp0})) begin
      if (q0.size() == 0) begin
        chk("unexpected0", {20'h0, rise0, fall0, hp0}, 32'h0);
      end else begin
        e0 = q0.pop_front();
        chk("edge0", cyc, e0.edg);
        chk("rise0", {28'h0, rise0}, {28'h0, e0.rise});
        chk("fall0", {28'h0, fall0}, {28'h0, e0.fall});
        chk("hpulse0", {28'h0, hp0}, {28'h0, e0.hp});
        chk("db0", {28'h0, db0}, {28'h0, e0.db});
        chk("tick_align0", {31'h0, tick0}, 32'h1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (|{rise1, fall1, hp1, hold1})) begin
      if (q1.size() == 0) begin
        chk("unexpected1", {16'h0, rise1, fall1, hp1, hold1}, 32'h0);
      end else begin
        e1 = q1.pop_front();
        chk("edge1", cyc, e1.edg);
        chk("rise1", {28'h0, rise1}, {28'h0, e1.rise});
        chk("fall1", {28'h0, fall1}, {28'h0, e1.fall});
        chk("db1", {28'h0, db1}, {28'h0, e1.db});
        chk("tick_align1", {31'h0, tick1}, 32'h1);
      end
    end
  end

  initial begin
    int n, r, f;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    btn0  = 4'h0;
    btn1  = 4'hF;

    // Power-on reset
    repeat (3) @(negedge clk);
    chk("por_out0", {11'h0, db0, rise0, fall0, hold0, hp0, tick0}, 32'h0);
    chk("por_out1", {11'h0, db1, rise1, fall1, hold1, hp1, tick1}, 32'h0);
    rst_n = 1'b1;

    // First tick lands on edge DIV after release
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("first_tick", {31'h0, tick0}, {31'h0, (cyc == DIV)});
    end

    // All channels pressed, then async reset mid-count while held
    n = cyc;
    btn0 = 4'hF;
    r = exp_edge(n, 4);
    push0(r, 4'hF, 4'h0, 4'h0, 4'hF);
    wait_until(r + 13);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {11'h0, db0, rise0, fall0, hold0, hp0, tick0}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_rst", {15'h0, db0, rise0, fall0, hp0, tick0}, 32'h0);
    end
    btn0 = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);

    // Clean press and release on ch0
    n = cyc;
    btn0[0] = 1'b1;
    push0(exp_edge(n, 4), 4'h1, 4'h0, 4'h0, 4'h1);
    repeat (60) @(negedge clk);
    n = cyc;
    btn0[0] = 1'b0;
    push0(exp_edge(n, 4), 4'h0, 4'h1, 4'h0, 4'h0);
    repeat (60) @(negedge clk);

    // Bounce on ch1: 15-clock half period never gives 4 agreeing samples
    for (int i = 0; i < 14; i++) begin
      btn0[1] = ~btn0[1];
      repeat (15) @(negedge clk);
    end
    n = cyc;
    btn0[1] = 1'b1;
    push0(exp_edge(n, 4), 4'h2, 4'h0, 4'h0, 4'h2);
    repeat (60) @(negedge clk);
    n = cyc;
    btn0[1] = 1'b0;
    push0(exp_edge(n, 4), 4'h0, 4'h2, 4'h0, 4'h0);
    repeat (60) @(negedge clk);

    // Glitch during release on ch3: 3 zero samples, 1 one, then steady 0
    n = cyc;
    btn0[3] = 1'b1;
    push0(exp_edge(n, 4), 4'h8, 4'h0, 4'h0, 4'h8);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 20 && (cyc % DIV) != 5; i++) @(negedge clk);
    btn0[3] = 1'b0;
    repeat (30) @(negedge clk);
    btn0[3] = 1'b1;
    repeat (10) @(negedge clk);
    n = cyc;
    btn0[3] = 1'b0;
    push0(exp_edge(n, 4), 4'h0, 4'h8, 4'h0, 4'h0);
    repeat (60) @(negedge clk);

    // Active-low instance: pins F -> 5 presses channels 1 and 3 together
    n = cyc;
    btn1 = 4'h5;
    push1(exp_edge(n, 4), 4'hA, 4'h0, 4'hA);
    repeat (60) @(negedge clk);
    n = cyc;
    btn1 = 4'hF;
    push1(exp_edge(n, 4), 4'h0, 4'hA, 4'h0);
    repeat (60) @(negedge clk);

    // Hold on ch2 for 30 ticks
    n = cyc;
    btn0[2] = 1'b1;
    r = exp_edge(n, 4);
    push0(r, 4'h4, 4'h0, 4'h0, 4'h4);
    if (HOLD_ON) push0(r + 20 * DIV, 4'h0, 4'h0, 4'h4, 4'h4);
    wait_until(r + 20 * DIV - 1);
    chk("hold_before", {28'h0, hold0}, 32'h0);
    wait_until(r + 25 * DIV);
    chk("hold_lvl", {28'h0, hold0}, {31'h0, HOLD_ON} << 2);
    wait_until(r + 30 * DIV);
    n = cyc;
    btn0[2] = 1'b0;
    f = exp_edge(n, 4);
    push0(f, 4'h0, 4'h4, 4'h0, 4'h0);
    wait_until(f - 1);
    chk("hold_pre_fall", {28'h0, hold0}, {31'h0, HOLD_ON} << 2);
    wait_until(f);
    chk("hold_clr", {28'h0, hold0}, 32'h0);
    repeat (20) @(negedge clk);

    chk("q0_empty", q0.size(), 32'h0);
    chk("q1_empty", q1.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
